// File: rtl/periph_fifo_drain_if.sv
// Handshake bundle between the FIFO drain engine, the async FIFO read side
// and the downstream byte sink.
interface periph_fifo_drain_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  // FIFO read side
  logic                  periph_empty_i;
  logic                  periph_rd_en_o;
  logic [DATA_WIDTH-1:0] periph_rdata_i;
  logic                  periph_rvalid_i;

  // Serialized byte stream
  logic [7:0]            byte_data_o;
  logic                  byte_valid_o;
  logic                  byte_ready_i;
  logic                  byte_last_o;

  modport master (
    output periph_rd_en_o,
    output byte_data_o,
    output byte_valid_o,
    output byte_last_o,
    input  periph_empty_i,
    input  periph_rdata_i,
    input  periph_rvalid_i,
    input  byte_ready_i
  );

  modport slave (
    input  periph_rd_en_o,
    input  byte_data_o,
    input  byte_valid_o,
    input  byte_last_o,
    output periph_empty_i,
    output periph_rdata_i,
    output periph_rvalid_i,
    output byte_ready_i
  );
endinterface

// File: rtl/periph_fifo_drain.sv
// Pops words from the read side of an async FIFO, one at a time, and streams
// each word out LSB byte first over a valid/ready byte interface.
module periph_fifo_drain #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic                 clk_periph,
  input  logic                 periph_rst_i,
  input  logic                 enable_i,
  periph_fifo_drain_if.master  bus,
  output logic [CNT_WIDTH-1:0] words_drained_o,
  output logic                 busy_o,
  output logic                 rd_timeout_o
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 2);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    SEND
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic                  timeout_d;
  logic                  can_pop_c;
  logic                  last_c;

  assign can_pop_c = enable_i && !bus.periph_empty_i;
  assign last_c    = (idx_q == IDX_W'(NBYTES - 1));

  // The word register shifts right as bytes leave, so the current byte is
  // always its low byte and comes straight from a flop.
  assign bus.byte_data_o = word_q[7:0];

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    cnt_d     = words_drained_o;
    timeout_d = rd_timeout_o;

    unique case (state_q)
      IDLE: begin
        if (can_pop_c) begin
          state_d = REQ;
        end
      end

      REQ: begin
        tmo_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (bus.periph_rvalid_i) begin
          word_d  = bus.periph_rdata_i;
          idx_d   = '0;
          state_d = SEND;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      SEND: begin
        if (bus.byte_ready_i) begin
          if (last_c) begin
            word_d  = '0;
            idx_d   = '0;
            cnt_d   = words_drained_o + 1'b1;
            state_d = can_pop_c ? REQ : IDLE;
          end else begin
            word_d = word_q >> 8;
            idx_d  = idx_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs, all decoded from next state
  always_ff @(posedge clk_periph) begin
    if (periph_rst_i) begin
      state_q          <= IDLE;
      word_q           <= '0;
      idx_q            <= '0;
      tmo_q            <= '0;
      words_drained_o  <= '0;
      rd_timeout_o     <= 1'b0;
      busy_o           <= 1'b0;
      bus.periph_rd_en_o <= 1'b0;
      bus.byte_valid_o <= 1'b0;
      bus.byte_last_o  <= 1'b0;
    end else begin
      state_q          <= state_d;
      word_q           <= word_d;
      idx_q            <= idx_d;
      tmo_q            <= tmo_d;
      words_drained_o  <= cnt_d;
      rd_timeout_o     <= timeout_d;
      busy_o           <= (state_d != IDLE);
      bus.periph_rd_en_o <= (state_d == REQ);
      bus.byte_valid_o <= (state_d == SEND);
      bus.byte_last_o  <= (state_d == SEND) && (idx_d == IDX_W'(NBYTES - 1));
    end
  end

endmodule

// File: tb/tb_periph_fifo_drain.sv
// Directed bench for periph_fifo_drain: reset, single word, backpressure,
// back-to-back words, enable drop, read timeout, mid-word reset, counter wrap.
module tb_periph_fifo_drain;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rst2;
  logic          en;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          tmo;
  logic [1:0]    cnt2;
  logic          busy2;
  logic          tmo2;

  int total     = 0;
  int bad       = 0;
  int rd_pulses = 0;

  logic [7:0] got_data[$];
  logic       got_last[$];
  logic [7:0] exp_b[8];

  always #5 clk = ~clk;

  periph_fifo_drain_if #(.DATA_WIDTH(DW)) bus ();
  periph_fifo_drain_if #(.DATA_WIDTH(8))  bus2 ();

  periph_fifo_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .TIMEOUT_CYC(15)) dut (
    .clk_periph      (clk),
    .periph_rst_i    (rst),
    .enable_i        (en),
    .bus             (bus),
    .words_drained_o (cnt),
    .busy_o          (busy),
    .rd_timeout_o    (tmo)
  );

  // Narrow instance with a 2-bit counter, fed by an always-ready FIFO model
  periph_fifo_drain #(.DATA_WIDTH(8), .CNT_WIDTH(2), .TIMEOUT_CYC(15)) dut2 (
    .clk_periph      (clk),
    .periph_rst_i    (rst2),
    .enable_i        (1'b1),
    .bus             (bus2),
    .words_drained_o (cnt2),
    .busy_o          (busy2),
    .rd_timeout_o    (tmo2)
  );

  assign bus2.periph_empty_i = 1'b0;
  assign bus2.byte_ready_i   = 1'b1;
  assign bus2.periph_rdata_i = 8'hA5;
  always @(posedge clk) bus2.periph_rvalid_i <= (bus2.periph_rd_en_o === 1'b1);

  // Pop-pulse counter and accepted-byte log for the main instance
  always @(posedge clk) begin
    if (bus.periph_rd_en_o === 1'b1) rd_pulses++;
    if (bus.byte_valid_o === 1'b1 && bus.byte_ready_i === 1'b1) begin
      got_data.push_back(bus.byte_data_o);
      got_last.push_back(bus.byte_last_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd_en"}, 32'(bus.periph_rd_en_o), 32'd0);
    chk({tag, "_valid"}, 32'(bus.byte_valid_o), 32'd0);
    chk({tag, "_last"},  32'(bus.byte_last_o), 32'd0);
    chk({tag, "_data"},  32'(bus.byte_data_o), 32'd0);
    chk({tag, "_cnt"},   32'(cnt), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_tmo"},   32'(tmo), 32'd0);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] d, input logic l);
    chk({tag, "_valid"}, 32'(bus.byte_valid_o), 32'd1);
    chk({tag, "_data"},  32'(bus.byte_data_o), 32'(d));
    chk({tag, "_last"},  32'(bus.byte_last_o), 32'(l));
  endtask

  // From IDLE with data available: pop, answer one cycle after rd_en, land in SEND
  task automatic start_word(input string tag, input logic [31:0] w, input logic more);
    bus.periph_empty_i = 1'b0;
    tick();
    chk({tag, "_rd_en"}, 32'(bus.periph_rd_en_o), 32'd1);
    chk({tag, "_busy"},  32'(busy), 32'd1);
    bus.periph_empty_i = !more;
    tick();
    chk({tag, "_rd_en_drop"}, 32'(bus.periph_rd_en_o), 32'd0);
    chk({tag, "_wait_valid"}, 32'(bus.byte_valid_o), 32'd0);
    bus.periph_rvalid_i = 1'b1;
    bus.periph_rdata_i  = w;
    tick();
    bus.periph_rvalid_i = 1'b0;
    bus.periph_rdata_i  = '0;
  endtask

  task automatic drain4(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3);
    expect_byte({tag, "_b0"}, b0, 1'b0); tick();
    expect_byte({tag, "_b1"}, b1, 1'b0); tick();
    expect_byte({tag, "_b2"}, b2, 1'b0); tick();
    expect_byte({tag, "_b3"}, b3, 1'b1); tick();
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; en = 1'b1;
    bus.periph_empty_i  = 1'b0;
    bus.periph_rvalid_i = 1'b0;
    bus.periph_rdata_i  = '0;
    bus.byte_ready_i    = 1'b1;

    // Reset held two cycles with data available and enable high
    tick(); chk_reset("rst_c1");
    tick(); chk_reset("rst_c2");
    chk("rst_no_pop", 32'(rd_pulses), 32'd0);

    // Single word, full throughput
    rst = 1'b0;
    got_data.delete(); got_last.delete();
    start_word("t1", 32'hDEADBEEF, 1'b0);
    drain4("t1", 8'hEF, 8'hBE, 8'hAD, 8'hDE);
    chk("t1_cnt",    32'(cnt), 32'd1);
    chk("t1_idle",   32'(busy), 32'd0);
    chk("t1_vld0",   32'(bus.byte_valid_o), 32'd0);
    chk("t1_last0",  32'(bus.byte_last_o), 32'd0);
    chk("t1_pulses", 32'(rd_pulses), 32'd1);
    chk("t1_nbytes", 32'(got_data.size()), 32'd4);

    // Backpressure: BE held for three cycles
    got_data.delete(); got_last.delete();
    start_word("t2", 32'hDEADBEEF, 1'b0);
    expect_byte("t2_b0", 8'hEF, 1'b0); tick();
    expect_byte("t2_b1", 8'hBE, 1'b0);
    bus.byte_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_byte("t2_hold", 8'hBE, 1'b0);
    end
    bus.byte_ready_i = 1'b1;
    tick();
    expect_byte("t2_b2", 8'hAD, 1'b0); tick();
    expect_byte("t2_b3", 8'hDE, 1'b1); tick();
    chk("t2_cnt",    32'(cnt), 32'd2);
    chk("t2_nbytes", 32'(got_data.size()), 32'd4);
    chk("t2_byte1",  32'(got_data[1]), 32'hBE);

    // Back-to-back words; second pop the cycle after DE is accepted
    got_data.delete(); got_last.delete();
    start_word("t3", 32'hDEADBEEF, 1'b1);
    drain4("t3a", 8'hEF, 8'hBE, 8'hAD, 8'hDE);
    chk("t3_rd_en2", 32'(bus.periph_rd_en_o), 32'd1);
    chk("t3_cnt1",   32'(cnt), 32'd3);
    chk("t3_gap",    32'(bus.byte_valid_o), 32'd0);
    bus.periph_empty_i = 1'b1;
    tick();
    chk("t3_rd_en2_drop", 32'(bus.periph_rd_en_o), 32'd0);
    bus.periph_rvalid_i = 1'b1;
    bus.periph_rdata_i  = 32'hFEEDCAFE;
    tick();
    bus.periph_rvalid_i = 1'b0;
    bus.periph_rdata_i  = '0;
    drain4("t3b", 8'hFE, 8'hCA, 8'hED, 8'hFE);
    chk("t3_cnt2",   32'(cnt), 32'd4);
    chk("t3_pulses", 32'(rd_pulses), 32'd4);
    chk("t3_nbytes", 32'(got_data.size()), 32'd8);
    exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hFE, 8'hCA, 8'hED, 8'hFE};
    for (int i = 0; i < 8; i++) begin
      if (i < got_data.size()) begin
        chk("t3_order", 32'(got_data[i]), 32'(exp_b[i]));
        chk("t3_lastflag", 32'(got_last[i]), (i == 3 || i == 7) ? 32'd1 : 32'd0);
      end
    end

    // Enable dropped mid-SEND: word completes, no further pop
    start_word("t4", 32'h01020304, 1'b1);
    en = 1'b0;
    drain4("t4", 8'h04, 8'h03, 8'h02, 8'h01);
    chk("t4_cnt",    32'(cnt), 32'd5);
    chk("t4_idle",   32'(busy), 32'd0);
    chk("t4_pulses", 32'(rd_pulses), 32'd5);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_no_pop",  32'(bus.periph_rd_en_o), 32'd0);
      chk("t4_no_busy", 32'(busy), 32'd0);
    end
    chk("t4_pulses_end", 32'(rd_pulses), 32'd5);

    // Read timeout: 16 WAIT cycles without rvalid
    en = 1'b1;
    tick();
    chk("t5_rd_en", 32'(bus.periph_rd_en_o), 32'd1);
    bus.periph_empty_i = 1'b1;
    tick();
    chk("t5_wait_tmo", 32'(tmo), 32'd0);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("t5_pending_tmo",  32'(tmo), 32'd0);
      chk("t5_pending_busy", 32'(busy), 32'd1);
    end
    tick();
    chk("t5_tmo",   32'(tmo), 32'd1);
    chk("t5_idle",  32'(busy), 32'd0);
    chk("t5_vld",   32'(bus.byte_valid_o), 32'd0);
    // Stray rvalid outside WAIT is ignored
    bus.periph_rvalid_i = 1'b1;
    bus.periph_rdata_i  = 32'h12345678;
    tick();
    bus.periph_rvalid_i = 1'b0;
    bus.periph_rdata_i  = '0;
    chk("t5_stray_busy", 32'(busy), 32'd0);
    chk("t5_stray_vld",  32'(bus.byte_valid_o), 32'd0);
    chk("t5_stray_data", 32'(bus.byte_data_o), 32'd0);
    chk("t5_stray_cnt",  32'(cnt), 32'd5);
    // Timeout flag survives a later successful word
    start_word("t5w", 32'h55667788, 1'b0);
    drain4("t5w", 8'h88, 8'h77, 8'h66, 8'h55);
    chk("t5_cnt",    32'(cnt), 32'd6);
    chk("t5_sticky", 32'(tmo), 32'd1);

    // Reset mid-word discards the rest and clears everything
    start_word("t6", 32'hDEADBEEF, 1'b0);
    expect_byte("t6_b0", 8'hEF, 1'b0); tick();
    expect_byte("t6_b1", 8'hBE, 1'b0);
    rst = 1'b1;
    tick();
    chk_reset("t6_rst");
    rst = 1'b0;
    tick(); tick();
    chk("t6_idle", 32'(busy), 32'd0);
    chk("t6_cnt",  32'(cnt), 32'd0);
    chk("t6_vld",  32'(bus.byte_valid_o), 32'd0);

    // 2-bit counter wraps 3 -> 0 on the narrow instance
    rst2 = 1'b0;
    repeat (3) tick();
    chk("t7_vld",  32'(bus2.byte_valid_o), 32'd1);
    chk("t7_data", 32'(bus2.byte_data_o), 32'hA5);
    chk("t7_last", 32'(bus2.byte_last_o), 32'd1);
    chk("t7_busy", 32'(busy2), 32'd1);
    repeat (7) tick();
    chk("t7_cnt3", 32'(cnt2), 32'd3);
    repeat (3) tick();
    chk("t7_wrap", 32'(cnt2), 32'd0);
    repeat (3) tick();
    chk("t7_cnt1", 32'(cnt2), 32'd1);
    chk("t7_tmo",  32'(tmo2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/periph_fifo_drain.md
PERIPH_FIFO_DRAIN -- requirements
Module: periph_fifo_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, FIFO word width; multiple of 8.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the drained-word counter.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 15, maximum cycles to wait for periph_rvalid_i after a pop.
REQ-004 SHALL have clk_periph  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have periph_rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have enable_i  in  1  permits new pops when high.
REQ-007 SHALL have periph_empty_i  in  1  FIFO empty flag from the async FIFO read side.
REQ-008 SHALL have periph_rd_en_o  out  1  one-cycle pop request to the FIFO.
REQ-009 SHALL have periph_rdata_i  in  DATA_WIDTH  popped word, valid when periph_rvalid_i=1.
REQ-010 SHALL have periph_rvalid_i  in  1  one-cycle strobe marking periph_rdata_i valid.
REQ-011 SHALL have byte_data_o  out  8  serialized output byte.
REQ-012 SHALL have byte_valid_o  out  1  byte_data_o valid.
REQ-013 SHALL have byte_ready_i  in  1  downstream accepts the byte.
REQ-014 SHALL have byte_last_o  out  1  current byte is the last byte of its word.
REQ-015 SHALL have words_drained_o  out  CNT_WIDTH  count of fully sent words.
REQ-016 SHALL have busy_o  out  1  high in any state other than IDLE.
REQ-017 SHALL have rd_timeout_o  out  1  sticky flag: a pop received no rvalid within TIMEOUT_CYC.

Function
REQ-018 SHALL implement FSM states IDLE, REQ, WAIT, SEND; NBYTES = DATA_WIDTH/8.
REQ-019 IDLE: SHALL go to REQ when enable_i=1 and periph_empty_i=0; otherwise stay.
REQ-020 REQ: SHALL drive periph_rd_en_o=1 (registered) for exactly this one cycle, then go to WAIT.
REQ-021 periph_rd_en_o SHALL be 0 in every state other than REQ; at most one pop SHALL be outstanding.
REQ-022 WAIT: on periph_rvalid_i=1, SHALL capture periph_rdata_i into the word register, clear the byte index to 0, and go to SEND.
REQ-023 WAIT: SHALL count cycles; if TIMEOUT_CYC+1 cycles elapse without periph_rvalid_i, SHALL set rd_timeout_o=1 and go to IDLE.
REQ-024 periph_rvalid_i outside WAIT SHALL be ignored; no capture and no state change.
REQ-025 SEND: byte_valid_o=1; byte_data_o = word[8*idx+7:8*idx] (LSB byte first); byte_last_o=1 only when idx=NBYTES-1.
REQ-026 SEND: byte_data_o and byte_last_o SHALL remain stable while byte_valid_o=1 and byte_ready_i=0.
REQ-027 SEND: on byte_valid_o and byte_ready_i with idx<NBYTES-1, idx SHALL increment by 1, so one byte is sent per cycle at full throughput.
REQ-028 SEND, last byte accepted: words_drained_o SHALL increment by 1, wrapping modulo 2^CNT_WIDTH (all-ones to 0).
REQ-029 SEND, last byte accepted: SHALL go to REQ if enable_i=1 and periph_empty_i=0, else to IDLE.
REQ-030 enable_i deasserted in REQ/WAIT/SEND SHALL NOT abort: the current word completes and no further pop is issued.
REQ-031 byte_valid_o and byte_last_o SHALL be 0 outside SEND.
REQ-032 rd_timeout_o SHALL be cleared only by reset.

Reset
REQ-033 periph_rst_i=1 at a clock edge SHALL force IDLE and clear idx, the timeout counter and the word register; it SHALL drive periph_rd_en_o=0, byte_valid_o=0, byte_last_o=0, byte_data_o=0, words_drained_o=0, busy_o=0 and rd_timeout_o=0.
REQ-034 Reset mid-word SHALL discard the remaining bytes; the partial word SHALL NOT be counted.
REQ-035 Reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-036 Reset held 2 cycles with empty=0 and enable=1 -> all outputs 0 and no periph_rd_en_o pulse during reset.
REQ-037 Single word: empty=0, enable=1, rvalid one cycle after rd_en with 0xDEADBEEF, ready=1 -> bytes EF, BE, AD, DE on consecutive cycles; last only on DE; words_drained_o=1; one rd_en pulse.
REQ-038 Backpressure: ready=0 for 3 cycles after byte BE is presented -> BE held stable, then AD and DE follow; 4 bytes total.
REQ-039 Back-to-back: words 0xDEADBEEF then 0xFEEDCAFE with empty=0 -> second rd_en asserts the cycle after DE is accepted; 8 bytes in order; count=2.
REQ-040 Timeout: rd_en issued, rvalid never asserted -> rd_timeout_o=1 after 16 WAIT cycles; state IDLE; rd_timeout_o stays 1 until reset.
REQ-041 enable_i=0 with empty=0 for 20 cycles -> no rd_en pulse and busy_o=0; enable_i dropped mid-SEND -> word completes and no new pop.
